// File: rtl/cpu_pkg.sv
// Shared types and default widths for the accumulator CPU.
package cpu_pkg;

    localparam int CPU_ADDR_W = 5;
    localparam int CPU_OPC_W  = 3;

    // Encodings fixed by the controller's decode table.
    typedef enum logic [2:0] {
        HLT = 3'd0,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR
    } fetch_state_e;

endpackage

// File: rtl/pc_counter.sv
// Program counter: load beats increment, hold freezes both, wraps modulo 2^ADDR_W.
module pc_counter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic              hold,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= '0;
        end else if (!hold) begin
            if (load) begin
                pc_reg <= load_val;
            end else if (en) begin
                pc_reg <= pc_reg + 1'b1;
            end
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: ready/valid fetch FSM, IR, timeout watchdog and PC.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int OPC_W   = CPU_OPC_W,
    parameter int DATA_W  = ADDR_W + OPC_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ins_en,
    input  logic              pc_en,
    input  logic              pc_load,
    input  logic              halt,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [OPC_W-1:0]  opcode,
    output logic [ADDR_W-1:0] operand,
    output logic [ADDR_W-1:0] pc,
    output logic              ir_valid,
    output logic              fetch_busy,
    output logic              fetch_err
);

    fetch_state_e      state_reg, state_next;
    logic [DATA_W-1:0] ir_reg;
    logic              ir_valid_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        wait_cnt_reg;
    logic              halted_reg;
    logic              start;
    logic              accept;

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_ins_en && !halted_reg) begin
                    start      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // Data arriving on the last allowed cycle still wins over the timeout.
                if (imem_ready) begin
                    accept     = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt_reg == 8'(TIMEOUT - 1)) begin
                    state_next = ERR;
                end
            end
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_reg       <= '0;
            ir_valid_reg <= 1'b0;
            addr_reg     <= '0;
            wait_cnt_reg <= '0;
            halted_reg   <= 1'b0;
        end else begin
            halted_reg <= halted_reg | halt;
            if (start) begin
                addr_reg     <= pc;
                ir_valid_reg <= 1'b0;
                wait_cnt_reg <= '0;
            end else if (state_reg == WAIT && !imem_ready) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
            if (accept) begin
                ir_reg       <= imem_rdata;
                ir_valid_reg <= 1'b1;
            end
        end
    end

    pc_counter #(
        .ADDR_W(ADDR_W)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .en       (pc_en),
        .load     (pc_load),
        .hold     (halted_reg),
        .load_val (operand),
        .pc       (pc)
    );

    assign opcode     = ir_reg[DATA_W-1 -: OPC_W];
    assign operand    = ir_reg[ADDR_W-1:0];
    assign imem_addr  = addr_reg;
    assign ir_valid   = ir_valid_reg;
    assign imem_req   = (state_reg == WAIT);
    assign fetch_busy = (state_reg == WAIT);
    assign fetch_err  = (state_reg == ERR);

endmodule
